// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared FSM encoding and sizing helpers for fpu_addsub_scheduler
package fpu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  // Bits needed to hold a WAIT-cycle count from 0 up to to_cyc inclusive
  function automatic int unsigned to_cnt_w(input int unsigned to_cyc);
    return (to_cyc < 2) ? 1 : $clog2(to_cyc + 1);
  endfunction

  // Bits needed to index n requesters (at least one)
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_grant_pick.sv
// rtl/rr_grant_pick.sv - combinational round-robin pick: first active request at or after ptr
module rr_grant_pick
  import fpu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW  = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic [PW-1:0] w_cand;

  // Scan requesters in rotated order starting at i_ptr; keep the first hit
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = PW'((int'(i_ptr) + k) % NREQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_scheduler.sv
// rtl/fpu_addsub_scheduler.sv - round-robin front end for one FP add/sub unit (optional timeout: FPU_SCHED_TIMEOUT_EN)
module fpu_addsub_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int W      = 32,
  parameter int NREQ   = 4,
  parameter int TO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_op,
  input  logic [2*NREQ-1:0] req_rm,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_unf,
  output logic              rsp_err,
  output logic              fpu_beg,
  output logic              fpu_rst_fsm,
  output logic [W-1:0]      fpu_x,
  output logic [W-1:0]      fpu_y,
  output logic              fpu_op,
  output logic [1:0]        fpu_rm,
  input  logic              fpu_ready,
  input  logic [W-1:0]      fpu_result,
  input  logic              fpu_ovf,
  input  logic              fpu_unf,
  output logic              busy
);

  localparam int PW = ptr_w(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("fpu_addsub_scheduler: NREQ must be 2..8");
  end
  if (TO_CYC < 1) begin : g_bad_to
    $error("fpu_addsub_scheduler: TO_CYC must be at least 1");
  end

  sched_state_e  r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_tag;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_idx;
  logic            w_valid;
  logic [PW-1:0]   w_ptr_nxt;

  rr_grant_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_ptr_nxt = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + PW'(1);

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int CW = to_cnt_w(TO_CYC);
  logic [CW-1:0] r_cnt;
  logic          w_to;
  // r_cnt counts WAIT cycles already spent; this cycle is the TO_CYC-th one
  assign w_to = (int'(r_cnt) == TO_CYC - 1);
`else
  assign rsp_err = 1'b0;
`endif

  // Scheduler FSM; every handshake output is registered and pulses default low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_tag       <= '0;
      req_ack     <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_ovf     <= 1'b0;
      rsp_unf     <= 1'b0;
      fpu_beg     <= 1'b0;
      fpu_rst_fsm <= 1'b1;
      fpu_x       <= '0;
      fpu_y       <= '0;
      fpu_op      <= 1'b0;
      fpu_rm      <= '0;
      busy        <= 1'b0;
`ifdef FPU_SCHED_TIMEOUT_EN
      r_cnt       <= '0;
      rsp_err     <= 1'b0;
`endif
    end else begin
      req_ack     <= '0;
      rsp_valid   <= '0;
      fpu_beg     <= 1'b0;
      fpu_rst_fsm <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            fpu_x   <= req_x[int'(w_idx)*W +: W];
            fpu_y   <= req_y[int'(w_idx)*W +: W];
            fpu_op  <= req_op[w_idx];
            fpu_rm  <= req_rm[int'(w_idx)*2 +: 2];
            req_ack <= w_grant;
            r_tag   <= w_idx;
            r_ptr   <= w_ptr_nxt;
            fpu_beg <= 1'b1;
            busy    <= 1'b1;
            r_state <= ST_START;
`ifdef FPU_SCHED_TIMEOUT_EN
            rsp_err <= 1'b0;
`endif
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
`ifdef FPU_SCHED_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        ST_WAIT: begin
          if (fpu_ready) begin
            rsp_data    <= fpu_result;
            rsp_ovf     <= fpu_ovf;
            rsp_unf     <= fpu_unf;
            rsp_valid   <= NREQ'(1) << r_tag;
            fpu_rst_fsm <= 1'b1;
            r_state     <= ST_RESP;
          end
`ifdef FPU_SCHED_TIMEOUT_EN
          else if (w_to) begin
            rsp_data    <= '0;
            rsp_ovf     <= 1'b0;
            rsp_unf     <= 1'b0;
            rsp_err     <= 1'b1;
            rsp_valid   <= NREQ'(1) << r_tag;
            fpu_rst_fsm <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        ST_RESP: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_scheduler.sv
// tb/tb_fpu_addsub_scheduler.sv - self-checking bench for fpu_addsub_scheduler with a behavioural FP unit stub
module tb_fpu_addsub_scheduler;

  localparam int W      = 32;
  localparam int NREQ   = 4;
  localparam int TO_CYC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NREQ-1:0]   req;
  logic [W-1:0]      rx [NREQ];
  logic [W-1:0]      ry [NREQ];
  logic [NREQ-1:0]   rop;
  logic [1:0]        rrm [NREQ];
  logic [NREQ*W-1:0] req_x, req_y;
  logic [2*NREQ-1:0] req_rm;

  logic [NREQ-1:0] req_ack, rsp_valid;
  logic [W-1:0]    rsp_data, fpu_x, fpu_y;
  logic            rsp_ovf, rsp_unf, rsp_err, fpu_beg, fpu_rst_fsm, fpu_op, busy;
  logic [1:0]      fpu_rm;
  logic            fpu_ready = 1'b0;
  logic [W-1:0]    fpu_result = '0;
  logic            fpu_ovf = 1'b0;
  logic            fpu_unf = 1'b0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_x[g*W +: W]  = rx[g];
    assign req_y[g*W +: W]  = ry[g];
    assign req_rm[g*2 +: 2] = rrm[g];
  end

  fpu_addsub_scheduler #(.W(W), .NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y), .req_op(rop),
    .req_rm(req_rm), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_err(rsp_err), .fpu_beg(fpu_beg),
    .fpu_rst_fsm(fpu_rst_fsm), .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_op(fpu_op),
    .fpu_rm(fpu_rm), .fpu_ready(fpu_ready), .fpu_result(fpu_result),
    .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        unf;
  } res_t;

  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Single-precision add/sub via double arithmetic, truncating to 32 bits
  function automatic res_t calc(input logic [31:0] x, input logic [31:0] y, input logic op);
    real r;
    logic [63:0] d;
    int e;
    res_t o;
    r = op ? sp2r(x) - sp2r(y) : sp2r(x) + sp2r(y);
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    o = '0;
    if (d[62:0] == 63'd0) o.data = {d[63], 31'd0};
    else if (e >= 255) begin o.ovf = 1'b1; o.data = {d[63], 8'hFF, 23'd0}; end
    else if (e <= 0) begin o.unf = 1'b1; o.data = {d[63], 31'd0}; end
    else o.data = {d[63], 8'(e), d[51:29]};
    return o;
  endfunction

  function automatic logic [31:0] rand_fp();
    int unsigned sel;
    logic [7:0] e;
    sel = $urandom_range(0, 9);
    if (sel == 0)      e = 8'($urandom_range(250, 254));
    else if (sel == 1) e = 8'($urandom_range(1, 3));
    else               e = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  function automatic int rr_ref(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // FP unit stub: result after next_dly extra cycles, ready held until rst_FSM
  bit stub_hang = 1'b0;
  int next_dly  = 0;
  int stub_cnt  = 0;
  res_t stub_r;
  always @(posedge clk) begin
    if (fpu_rst_fsm === 1'b1) begin
      fpu_ready <= 1'b0;
      stub_cnt  <= 0;
    end else if (fpu_beg === 1'b1) begin
      stub_r      = calc(fpu_x, fpu_y, fpu_op);
      fpu_result <= stub_r.data;
      fpu_ovf    <= stub_r.ovf;
      fpu_unf    <= stub_r.unf;
      if (stub_hang) stub_cnt <= 0;
      else if (next_dly == 0) fpu_ready <= 1'b1;
      else stub_cnt <= next_dly;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) fpu_ready <= 1'b1;
    end
  end

  typedef struct {
    int          g;
    logic [31:0] x, y;
    logic        op;
    logic [1:0]  rm;
    res_t        r;
    int          due;
    bit          to;
  } exp_t;

  typedef struct {
    int          g;
    logic [31:0] d;
    logic        ovf, unf, err;
  } obs_t;

  exp_t q [$];
  exp_t m_e, m_h;
  int   ack_log [$];
  obs_t rsp_log [$];
  obs_t m_o;

  int cyc = 0;
  int m_ptr = 0;
  int n_beg = 0;
  int m_g, m_dly;
  bit p_idle = 1'b1, p_rsp = 1'b0, skip = 1'b1, m_cur_rsp, m_cur_idle;
  logic [NREQ-1:0] p_req, m_exp_ack, m_ev;
  logic [31:0] p_x [NREQ], p_y [NREQ];
  logic [NREQ-1:0] p_op;
  logic [1:0] p_rm [NREQ];

  task automatic snap();
    p_req = req;
    p_op  = rop;
    for (int i = 0; i < NREQ; i++) begin
      p_x[i] = rx[i]; p_y[i] = ry[i]; p_rm[i] = rrm[i];
    end
  endtask

  // Scoreboard: predicts grants, responses and their cycles from the request history
  always @(negedge clk) begin
    cyc++;
    if (fpu_beg === 1'b1) n_beg++;
    if (!rst) begin
      chk("rst_outs", {req_ack, rsp_valid, fpu_beg, busy, rsp_ovf, rsp_unf, rsp_err,
                       rsp_data, fpu_x, fpu_y, fpu_op, fpu_rm}, '0);
      chk("rst_fsm_hold", fpu_rst_fsm, 1);
      q.delete();
      m_ptr = 0; p_idle = 1'b1; p_rsp = 1'b0; skip = 1'b1;
      snap();
    end else if (skip) begin
      skip = 1'b0; p_idle = 1'b1; p_rsp = 1'b0;
      snap();
    end else begin
      m_exp_ack = '0;
      m_g = -1;
      if (p_idle && (|p_req)) begin
        m_g = rr_ref(p_req, m_ptr);
        m_exp_ack[m_g] = 1'b1;
      end
      chk("req_ack", req_ack, m_exp_ack);
      chk("fpu_beg", fpu_beg, |m_exp_ack);
      if (m_g >= 0) begin
        m_dly   = $urandom_range(0, 4);
        next_dly = m_dly;
        m_e.g  = m_g;  m_e.x = p_x[m_g]; m_e.y = p_y[m_g];
        m_e.op = p_op[m_g]; m_e.rm = p_rm[m_g];
        m_e.r  = calc(p_x[m_g], p_y[m_g], p_op[m_g]);
        m_e.to = stub_hang;
`ifdef FPU_SCHED_TIMEOUT_EN
        m_e.due = stub_hang ? cyc + TO_CYC + 1 : cyc + m_dly + 2;
`else
        m_e.due = stub_hang ? -1 : cyc + m_dly + 2;
`endif
        chk("err_clear", rsp_err, 0);
        m_ptr = (m_g + 1) % NREQ;
        ack_log.push_back(m_g);
        q.push_back(m_e);
      end
      if (q.size() > 0)
        chk("fpu_ops", {fpu_x, fpu_y, fpu_op, fpu_rm}, {q[0].x, q[0].y, q[0].op, q[0].rm});
      m_cur_rsp = (q.size() > 0) && (q[0].due == cyc);
      if (m_cur_rsp) begin
        m_h = q.pop_front();
        m_ev = '0;
        m_ev[m_h.g] = 1'b1;
        chk("rsp_valid", rsp_valid, m_ev);
        chk("rsp_data", rsp_data, m_h.to ? 32'd0 : m_h.r.data);
        chk("rsp_flags", {rsp_ovf, rsp_unf, rsp_err}, m_h.to ? 3'b001 : {m_h.r.ovf, m_h.r.unf, 1'b0});
        m_o.g = m_h.g; m_o.d = rsp_data; m_o.ovf = rsp_ovf; m_o.unf = rsp_unf; m_o.err = rsp_err;
        rsp_log.push_back(m_o);
      end else begin
        chk("rsp_quiet", rsp_valid, '0);
      end
      chk("rst_fsm_pulse", fpu_rst_fsm, m_cur_rsp);
      m_cur_idle = (p_idle && !(|p_req)) || p_rsp;
      chk("busy", busy, !m_cur_idle);
      p_idle = m_cur_idle;
      p_rsp  = m_cur_rsp;
      snap();
    end
  end

  logic [NREQ-1:0] keep = '0;
  bit rnd_mode = 1'b0;

  task automatic new_ops(input int i);
    rx[i] = rand_fp(); ry[i] = rand_fp();
    rop[i] = 1'($urandom_range(0, 1)); rrm[i] = 2'($urandom_range(0, 3));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ack[i] && !keep[i]) req[i] = 1'b0;
      if (rnd_mode) begin
        if (req[i] && $urandom_range(0, 40) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin new_ops(i); req[i] = 1'b1; end
      end
    end
  endtask

  task automatic wait_rsp(input int n, input int lim);
    int t;
    t = 0;
    while (rsp_log.size() < n && t < lim) begin tick(); t++; end
    chk("wait_rsp", rsp_log.size() >= n, 1);
  endtask

  task automatic wait_ack(input int n, input int lim);
    int t;
    t = 0;
    while (ack_log.size() < n && t < lim) begin tick(); t++; end
    chk("wait_ack", ack_log.size() >= n, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int beg0;

  initial begin
    req = '0; rop = '0;
    for (int i = 0; i < NREQ; i++) begin rx[i] = '0; ry[i] = '0; rrm[i] = '0; end
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) tick();

    // All four requesters at once from ptr=0
    ack_log.delete(); rsp_log.delete(); beg0 = n_beg;
    for (int i = 0; i < NREQ; i++) begin new_ops(i); rop[i] = 1'(i); rrm[i] = 2'(i); end
    req = 4'b1111;
    wait_rsp(4, 200);
    chk("all4_begs", n_beg - beg0, 4);
    for (int k = 0; k < 4; k++) begin
      if (ack_log.size() > k) chk("all4_ack_order", ack_log[k], k);
      if (rsp_log.size() > k) chk("all4_rsp_owner", rsp_log[k].g, k);
    end
    repeat (4) tick();

    // Fairness between two persistent requesters
    ack_log.delete(); rsp_log.delete();
    new_ops(0); new_ops(2);
    keep = 4'b0101; req = 4'b0101;
    wait_ack(6, 300);
    keep = '0; req = '0;
    repeat (12) tick();
    for (int k = 0; k < 6; k++)
      if (ack_log.size() > k) chk("fair_order", ack_log[k], (k % 2) * 2);

    // Single add 1.0 + 2.0
    rsp_log.delete();
    rx[0] = 32'h3F800000; ry[0] = 32'h40000000; rop[0] = 1'b0; rrm[0] = 2'd0;
    req[0] = 1'b1;
    wait_rsp(1, 100);
    if (rsp_log.size() > 0) begin
      chk("add_owner", rsp_log[0].g, 0);
      chk("add_data", rsp_log[0].d, 32'h40400000);
      chk("add_flags", {rsp_log[0].ovf, rsp_log[0].unf}, 2'b00);
    end
    repeat (3) tick();

    // Overflow: max finite + max finite
    rsp_log.delete();
    rx[2] = 32'h7F7FFFFF; ry[2] = 32'h7F7FFFFF; rop[2] = 1'b0;
    req[2] = 1'b1;
    wait_rsp(1, 100);
    if (rsp_log.size() > 0) begin
      chk("ovf_owner", rsp_log[0].g, 2);
      chk("ovf_flag", rsp_log[0].ovf, 1);
    end
    repeat (3) tick();

    // Reset while waiting on the unit
    ack_log.delete(); rsp_log.delete();
    stub_hang = 1'b1;
    new_ops(0); req[0] = 1'b1;
    wait_ack(1, 50);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rstw_outs", {rsp_valid, busy, rsp_data, fpu_x, fpu_y}, '0);
    chk("rstw_fsm", fpu_rst_fsm, 1);
    repeat (2) tick();
    stub_hang = 1'b0;
    rst = 1'b1;
    new_ops(1); req[1] = 1'b1;
    wait_rsp(1, 100);
    if (rsp_log.size() > 0) chk("rstw_next_owner", rsp_log[0].g, 1);
    repeat (3) tick();

`ifdef FPU_SCHED_TIMEOUT_EN
    // Unit never ready: timeout response
    rsp_log.delete();
    stub_hang = 1'b1;
    new_ops(3); req[3] = 1'b1;
    wait_rsp(1, TO_CYC + 50);
    if (rsp_log.size() > 0) begin
      chk("to_owner", rsp_log[0].g, 3);
      chk("to_err", rsp_log[0].err, 1);
      chk("to_data", rsp_log[0].d, 0);
    end
    stub_hang = 1'b0;
    repeat (3) tick();
`endif

    // Randomized traffic
    rnd_mode = 1'b1;
    repeat (3000) tick();
    rnd_mode = 1'b0;
    req = '0;
    repeat (20) tick();
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
